// File: rtl/pipe_stage_reg.sv
// Two-entry in-order skid-buffer pipeline stage with halt latching and flush.
// Upstream ready is decoded from registered state only, so it never depends on out_ready.
`timescale 1ns/1ps

module pipe_stage_reg #(
    parameter int unsigned       DATA_W  = 48,
    parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_halt,
    input  logic              flush,
    output logic              halted,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic              halt;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam entry_t NOP_ENTRY = '{halt: 1'b0, data: NOP_VAL};

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   halted_q, halted_d;
    logic   ready_q, ready_d;
    logic   accept, pop;

    assign in_entry = '{halt: in_halt, data: in_data};
    assign accept   = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

    // State register; reset discards stored entries and the halt latch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_EMPTY;
            halted_q <= 1'b0;
            ready_q  <= 1'b1;
            main_q   <= NOP_ENTRY;
            skid_q   <= NOP_ENTRY;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            ready_q  <= ready_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end

    // Next-state, storage movement and halt latch; flush overrides everything.
    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        halted_d = halted_q;

        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d = S_ONE;
                    main_d  = in_entry;
                end
            end
            S_ONE: begin
                if (accept && pop) begin
                    main_d = in_entry;
                end else if (accept) begin
                    state_d = S_FULL;
                    skid_d  = in_entry;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (pop) begin
                    state_d = S_ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase

        if (accept && in_halt) begin
            halted_d = 1'b1;
        end

        if (flush) begin
            state_d  = S_EMPTY;
            halted_d = 1'b0;
        end

        ready_d = (state_d != S_FULL) && !halted_d;
    end

    // Output decode from registered state; flush only gates upstream ready.
    always_comb begin
        in_ready  = ready_q & ~flush;
        halted    = halted_q;
        out_valid = 1'b0;
        out_data  = NOP_VAL;
        out_halt  = 1'b0;
        occupancy = 2'd0;

        case (state_q)
            S_ONE:   occupancy = 2'd1;
            S_FULL:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase

        if (state_q != S_EMPTY) begin
            out_valid = 1'b1;
            out_data  = main_q.data;
            out_halt  = main_q.halt;
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 48, payload width per entry (instruction + two 16-bit PCs).
REQ-002 Parameter NOP_VAL, default {DATA_W{1'b0}}, value driven on out_data when stage empty.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  upstream entry present.
REQ-006 in_ready  output  1  stage can accept entry this cycle.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 in_halt  input  1  entry is a halt instruction.
REQ-009 out_valid  output  1  head entry present.
REQ-010 out_ready  input  1  downstream consumes head this cycle.
REQ-011 out_data  output  DATA_W  head payload.
REQ-012 out_halt  output  1  halt flag of head entry.
REQ-013 flush  input  1  discard all entries (branch mispredict).
REQ-014 halted  output  1  sticky: halt entry accepted.
REQ-015 occupancy  output  2  entry count, 0..2.

Function
REQ-016 Storage SHALL be a 2-entry in-order skid buffer (main + skid); states EMPTY, ONE, FULL.
REQ-017 Accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-018 in_ready SHALL be 1 iff state != FULL and halted == 0 and flush == 0; registered, no combinational path from out_ready.
REQ-019 out_valid SHALL be 1 iff state != EMPTY; out_data/out_halt SHALL be the oldest entry, else NOP_VAL / 0.
REQ-020 EMPTY: accept -> ONE; else stay.
REQ-021 ONE: accept & !pop -> FULL; pop & !accept -> EMPTY; both or neither -> ONE (accepted entry replaces head if popped).
REQ-022 FULL: pop -> ONE with skid entry promoted to head; no accept possible.
REQ-023 Latency: entry accepted in cycle N SHALL appear on out_data in cycle N+1 when stage was empty.
REQ-024 Ordering SHALL be strict FIFO; no entry duplicated or dropped except by flush/reset.
REQ-025 Outputs SHALL hold stable while out_valid & !out_ready.
REQ-026 Accept with in_halt=1 SHALL set halted next cycle; further accepts blocked; queued entries still drain.
REQ-027 flush SHALL, next cycle: state EMPTY, occupancy 0, halted 0; same-cycle in_valid discarded; same-cycle pop still counts as consumed downstream.
REQ-028 flush SHALL have priority over accept, pop and halt set.
REQ-029 occupancy SHALL equal 0/1/2 for EMPTY/ONE/FULL.

Reset
REQ-030 rst=0 at a clock edge SHALL force state EMPTY, halted 0, occupancy 0, out_valid 0, out_data NOP_VAL, out_halt 0; in_ready 1 in the cycle after rst returns to 1.
REQ-031 Reset SHALL override flush and all handshakes, including mid-operation with FULL state; stored data discarded.
REQ-032 Reset has no effect between clock edges.

Verification
REQ-033 Pass-through: out_ready=1, push 0xA1,0xA2,0xA3 back-to-back -> out_data A1,A2,A3 on cycles N+1..N+3, occupancy stays 1.
REQ-034 Backpressure: out_ready=0, push 0xB1,0xB2 -> occupancy 2, in_ready 0, 0xB3 held upstream; release out_ready -> B1,B2,B3 in order, none lost.
REQ-035 Flush when FULL with in_valid=1 (0xC3) -> next cycle out_valid 0, out_data NOP_VAL, C3 never emitted.
REQ-036 Halt: push 0xD1, then 0xD2 with in_halt=1 -> halted=1 next cycle, in_ready 0; D1 then D2 drain with out_halt=0 then 1.
REQ-037 Reset mid-operation: FULL with halted=1, drive rst=0 one edge -> all outputs at reset values, in_ready 1 after release.
REQ-038 Simultaneous accept+pop in ONE for 10 cycles -> occupancy constant 1, each output one cycle after its input.
